// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection: first active requester after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  logic [NUM_REQ-1:0] act;

  assign act = req & mask;

  // Scan from ptr+1 upward so the last winner is considered last.
  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!valid && act[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters (round-robin),
// with a launch-to-done timeout that aborts a stuck transfer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_en,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic [ID_W-1:0]      err_id,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_newd,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e                state;
  logic [NUM_REQ-1:0][7:0]   slot;
  logic [IW-1:0]             gidx, eidx, last_g, pick_idx;
  logic                      pick_vld;
  logic [CW-1:0]             cnt;
  logic                      tx_done_q;
  logic                      done_rise;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[8*i +: 8];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .mask  (req_en),
    .ptr   (last_g),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // A done level already high when SEND starts has tx_done_q=1, so it is not a rise.
  assign done_rise = tx_done & ~tx_done_q;
  assign grant_id  = ID_W'(gidx);
  assign err_id    = ID_W'(eidx);

  // Arbiter FSM; every output is registered here. Winner index and byte are
  // captured on the IDLE->GRANT edge so they are already valid during GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_newd   <= 1'b0;
      tx_data   <= '0;
      ack       <= '0;
      err       <= 1'b0;
      eidx      <= '0;
      busy      <= 1'b0;
      gidx      <= '0;
      last_g    <= IW'(NUM_REQ - 1);
      cnt       <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      ack       <= '0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= GRANT;
            busy    <= 1'b1;
            gidx    <= pick_idx;
            tx_data <= slot[pick_idx];
          end
        end
        GRANT: begin
          cnt     <= '0;
          tx_newd <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          cnt <= cnt + CW'(1);
          // A rise on the final timeout cycle still counts as success.
          if (done_rise) begin
            tx_newd <= 1'b0;
            ack     <= NUM_REQ'(1) << gidx;
            state   <= ACK;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            tx_newd <= 1'b0;
            err     <= 1'b1;
            eidx    <= gidx;
            last_g  <= gidx;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        ACK: begin
          last_g <= gidx;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: random transfers against a
// round-robin/timeout reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_en, ack;
  logic [8*N-1:0] req_data;
  logic           err, busy, tx_newd, tx_done;
  logic [2:0]     err_id, grant_id;
  logic [7:0]     tx_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         last_g;
  logic [7:0] data [N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_en   (req_en),
    .ack      (ack),
    .err      (err),
    .err_id   (err_id),
    .busy     (busy),
    .grant_id (grant_id),
    .tx_newd  (tx_newd),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Reference arbitration: first active index after the last winner, wrapping.
  function automatic int rr_next(input int last, input logic [N-1:0] act);
    for (int k = 1; k <= N; k++)
      if (act[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic load_data();
    for (int i = 0; i < N; i++) begin
      data[i] = 8'($urandom);
      req_data[8*i +: 8] = data[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_g = N - 1;
  endtask

  // One transfer: d = cycle (1-based) of tx_newd on which tx_done rises,
  // d = 0 or d > TMO means never (timeout expected).
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] e, input int d,
                         input bit keep, input bit pre_high, input bit reload);
    int w, n, hi, exp_hi;
    w = rr_next(last_g, r & e);
    if (reload) load_data();
    req = r;
    req_en = e;
    if (pre_high) tx_done = 1'b1;
    n = 0;
    while (tx_newd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (tx_newd !== 1'b1) begin
      n_bad++;
      $display("FAIL launch: tx_newd=%b, required 1 within 20 cycles", tx_newd);
      return;
    end
    n_cmp++;
    if (grant_id !== 3'(w)) begin
      n_bad++;
      $display("FAIL grant_id: got %0d, required %0d", grant_id, w);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_send: got %b, required 1", busy);
    end
    // Changes after the grant must not disturb the transfer in flight.
    if (!keep) begin
      req = '0;
      req_en = N'($urandom);
      req_data = ~req_data;
    end
    exp_hi = (d >= 1 && d <= TMO) ? d : TMO;
    hi = 0;
    while (tx_newd === 1'b1 && hi < TMO + 5) begin
      hi++;
      if (pre_high && hi == 5) tx_done = 1'b0;
      if (hi == d) tx_done = 1'b1;
      n_cmp++;
      if (tx_data !== data[w]) begin
        n_bad++;
        $display("FAIL tx_data: got %02h, required %02h (cycle %0d)", tx_data, data[w], hi);
      end
      @(negedge clk);
    end
    tx_done = 1'b0;
    n_cmp++;
    if (hi !== exp_hi) begin
      n_bad++;
      $display("FAIL newd_len: tx_newd high %0d cycles, required %0d", hi, exp_hi);
    end
    if (exp_hi == d) begin
      n_cmp++;
      if (ack !== (N'(1) << w) || err !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL ack_pulse: ack=%b err=%b busy=%b, required ack=%b err=0 busy=1",
                 ack, err, busy, N'(1) << w);
      end
    end else begin
      n_cmp++;
      if (err !== 1'b1 || err_id !== 3'(w) || ack !== '0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout: err=%b err_id=%0d ack=%b busy=%b, required err=1 err_id=%0d ack=0 busy=0",
                 err, err_id, ack, busy, w);
      end
    end
    last_g = w;
    @(negedge clk);
    n_cmp++;
    if (ack !== '0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_width: ack=%b err=%b one cycle later, required 0/0", ack, err);
    end
  endtask

  task automatic test_reset();
    req = '0; req_en = '0; req_data = '0; tx_done = 1'b0;
    do_reset();
    n_cmp++;
    if (tx_newd !== 1'b0 || tx_data !== 8'h00 || ack !== '0 || err !== 1'b0 ||
        err_id !== 3'd0 || busy !== 1'b0 || grant_id !== 3'd0) begin
      n_bad++;
      $display("FAIL reset: newd=%b data=%02h ack=%b err=%b err_id=%0d busy=%b gid=%0d, required all 0",
               tx_newd, tx_data, ack, err, err_id, busy, grant_id);
    end
  endtask

  task automatic test_idle_ignore();
    req = '1; req_en = '0;
    for (int i = 0; i < 8; i++) begin
      tx_done = i[1];
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || ack !== '0 || tx_newd !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_masked: busy=%b ack=%b newd=%b, required 0", busy, ack, tx_newd);
      end
    end
    req = '0; tx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    load_data();
    data[1] = 8'hA5;
    req_data[15:8] = 8'hA5;
    run_txn(4'b0010, 4'b1111, 50, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    load_data();
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b1111, int'($urandom_range(1, 40)), 1, 0, 0);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_mask();
    load_data();
    for (int i = 0; i < 6; i++) run_txn(4'b1111, 4'b1011, int'($urandom_range(1, 30)), 1, 0, 0);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    load_data();
    run_txn(4'b1111, 4'b1111, 0, 1, 0, 0);
    run_txn(4'b1111, 4'b1111, TMO, 1, 0, 0);
    run_txn(4'b1111, 4'b1111, TMO + 1, 1, 0, 0);
    run_txn(4'b1111, 4'b1111, 12, 1, 0, 0);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_pre_high();
    run_txn(4'b0100, 4'b1111, 30, 0, 1, 1);
  endtask

  task automatic test_rst_mid();
    int n;
    load_data();
    req = 4'b0100; req_en = '1;
    n = 0;
    while (tx_newd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    last_g = N - 1;
    n_cmp++;
    if (tx_newd !== 1'b0 || busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: newd=%b busy=%b ack=%b err=%b, required all 0", tx_newd, busy, ack, err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ack !== '0 || err !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_quiet: ack=%b err=%b busy=%b, required 0", ack, err, busy);
      end
    end
    run_txn(4'b1111, 4'b1111, 15, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [N-1:0] r, e;
    int d;
    for (int i = 0; i < 25; i++) begin
      do begin
        r = N'($urandom);
        e = N'($urandom);
      end while ((r & e) == '0);
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO + 10));
      run_txn(r, e, d, 0, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_en = '0; req_data = '0; tx_done = 1'b0; last_g = N - 1;
    test_reset();
    test_idle_ignore();
    test_single();
    test_round_robin();
    test_mask();
    test_timeout();
    test_pre_high();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
